// File: rtl/dram_word_adapter.sv
// dram_word_adapter: single-outstanding 32-bit word port onto a 128-bit DRAM app port.
// Optional one-line read buffer is built when DRAM_ADAPTER_LINEBUF_EN is defined.
module dram_word_adapter #(
  parameter int APP_ADDR_WIDTH = 27,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  input  logic                      i_req_we,
  input  logic [APP_ADDR_WIDTH:0]   i_req_addr,
  input  logic [31:0]               i_req_wdata,
  input  logic [3:0]                i_req_be,
  output logic                      o_req_ready,
  output logic                      o_rsp_valid,
  output logic [31:0]               o_rsp_rdata,
  output logic                      o_rd_en,
  output logic                      o_wr_en,
  output logic [APP_ADDR_WIDTH-1:0] o_addr,
  output logic [APP_DATA_WIDTH-1:0] o_data,
  output logic [APP_MASK_WIDTH-1:0] o_mask,
  input  logic [APP_DATA_WIDTH-1:0] i_data,
  input  logic                      i_data_valid,
  input  logic                      i_ready,
  input  logic                      i_wdf_ready,
  input  logic                      i_init_calib_complete
);

  localparam int TAG_W = APP_ADDR_WIDTH - 3;

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RSP, COOL
  } state_t;

  state_t           state;
  logic [TAG_W-1:0] tag;
  logic [1:0]       lane;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic             cool_hold;
  logic             go;
  logic             unused;

  assign go     = i_init_calib_complete & i_ready & i_wdf_ready;
  assign unused = ^i_req_addr[1:0];

`ifdef DRAM_ADAPTER_LINEBUF_EN
  logic                      lb_valid;
  logic [TAG_W-1:0]          lb_tag;
  logic [APP_DATA_WIDTH-1:0] lb_data;
  logic                      hit;

  assign hit = lb_valid && (lb_tag == i_req_addr[APP_ADDR_WIDTH:4]);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rd_en     <= 1'b0;
      o_wr_en     <= 1'b0;
      o_addr      <= '0;
      o_data      <= '0;
      o_mask      <= '0;
      tag         <= '0;
      lane        <= '0;
      wdata       <= '0;
      be          <= '0;
      cool_hold   <= 1'b0;
`ifdef DRAM_ADAPTER_LINEBUF_EN
      lb_valid    <= 1'b0;
      lb_tag      <= '0;
      lb_data     <= '0;
`endif
    end else begin
      o_wr_en     <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          o_req_ready <= 1'b1;
          if (i_req_valid && o_req_ready) begin
            o_req_ready <= 1'b0;
            tag   <= i_req_addr[APP_ADDR_WIDTH:4];
            lane  <= i_req_addr[3:2];
            wdata <= i_req_wdata;
            be    <= i_req_be;
            if (i_req_we) begin
              state <= WR_ISSUE;
`ifdef DRAM_ADAPTER_LINEBUF_EN
              // write-through: keep the buffered copy coherent
              if (hit) begin
                for (int b = 0; b < 4; b++) begin
                  if (i_req_be[b]) begin
                    lb_data[{i_req_addr[3:2], 2'(b), 3'b000} +: 8]
                      <= i_req_wdata[{2'(b), 3'b000} +: 8];
                  end
                end
              end
`endif
            end
`ifdef DRAM_ADAPTER_LINEBUF_EN
            else if (hit) begin
              state       <= RSP;
              o_rsp_valid <= 1'b1;
              o_rsp_rdata <= lb_data[{i_req_addr[3:2], 5'b0} +: 32];
            end
`endif
            else begin
              state <= RD_ISSUE;
            end
          end
        end
        WR_ISSUE: begin
          if (go) begin
            o_wr_en   <= 1'b1;
            o_addr    <= {tag, 3'b000};
            o_data    <= APP_DATA_WIDTH'(wdata) << {lane, 5'b0};
            o_mask    <= ~(APP_MASK_WIDTH'(be) << {lane, 2'b00});
            cool_hold <= 1'b1;
            state     <= COOL;
          end
        end
        RD_ISSUE: begin
          if (go) begin
            o_rd_en <= 1'b1;
            o_addr  <= {tag, 3'b000};
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (i_data_valid) begin
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= i_data[{lane, 5'b0} +: 32];
`ifdef DRAM_ADAPTER_LINEBUF_EN
            lb_valid    <= 1'b1;
            lb_tag      <= tag;
            lb_data     <= i_data;
`endif
            state       <= RSP;
          end
        end
        RSP: begin
          o_req_ready <= 1'b1;
          state       <= IDLE;
        end
        COOL: begin
          // first cycle is the pulse itself; controller ready lags a cycle
          if (cool_hold) begin
            cool_hold <= 1'b0;
          end else if (i_ready) begin
            o_req_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
